// File: rtl/block_pkg.sv
// block_pkg: definitions shared by the 4x4 block loader.
//   state_t            - controller state encoding (IDLE, FILL, FULL)
//   W_DEF/N_DEF/LOGN_DEF - default pixel width, pixels per block, address width
package block_pkg;

    localparam int W_DEF    = 8;
    localparam int N_DEF    = 16;
    localparam int LOGN_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

endpackage

// File: rtl/blk_addr_map.sv
// blk_addr_map: maps the pixel counter onto a block register address.
//   k    (in)  - pixel index within the block
//   mode (in)  - 0 = row-major (addr = k), 1 = column-major (row/col swapped)
//   addr (out) - block register write address
module blk_addr_map
    import block_pkg::*;
#(
    parameter int LOGN = LOGN_DEF
) (
    input  logic [LOGN-1:0] k,
    input  logic            mode,
    output logic [LOGN-1:0] addr
);

    localparam int H = LOGN / 2;

    // Swapping the low and high halves of k transposes the square block.
    assign addr = mode ? {k[H-1:0], k[LOGN-1:H]} : k;

endmodule

// File: rtl/block_load_ctrl.sv
// block_load_ctrl: collects a stream of pixels into a 4x4 block register,
// in row- or column-major order, and hands the completed block downstream.
//   CLK, RST        - clock, asynchronous active-high reset
//   PIX_VALID/DATA  - upstream pixel stream; PIX_READY = accepting
//   MODE            - write order, sampled on the first pixel of each block
//   FLUSH           - synchronous abort of the block being loaded
//   WR/ADDR_W/DATA_W- write port of the block register (same-cycle as accept)
//   BLK_VALID       - block register holds a complete block
//   BLK_ACK         - downstream consumed the block
//   BLK_CNT         - completed block count, wraps 255 -> 0
module block_load_ctrl
    import block_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int N    = N_DEF,
    parameter int LOGN = LOGN_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            PIX_VALID,
    input  logic [W-1:0]    PIX_DATA,
    output logic            PIX_READY,
    input  logic            MODE,
    input  logic            FLUSH,
    output logic            WR,
    output logic [LOGN-1:0] ADDR_W,
    output logic [W-1:0]    DATA_W,
    output logic            BLK_VALID,
    input  logic            BLK_ACK,
    output logic [7:0]      BLK_CNT
);

    localparam logic [LOGN-1:0] K_LAST = LOGN'(N - 1);

    state_t          state, state_nxt;
    logic [LOGN-1:0] k, k_nxt;
    logic            mode_q, mode_nxt;
    logic            mode_eff;
    logic            accept;
    logic            cnt_inc;

    // Ready is held low through reset itself, not just after it.
    assign PIX_READY = ~RST & ~FLUSH & (state != FULL);
    assign accept    = PIX_VALID & PIX_READY;
    assign WR        = accept;
    assign DATA_W    = PIX_DATA;
    assign BLK_VALID = (state == FULL);

    // The first pixel of a block is addressed with the live MODE, since the
    // latched copy only takes that value on the same edge.
    assign mode_eff = (state == IDLE) ? MODE : mode_q;

    blk_addr_map #(.LOGN(LOGN)) u_addr_map (
        .k    (k),
        .mode (mode_eff),
        .addr (ADDR_W)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt = state;
        k_nxt     = k;
        mode_nxt  = mode_q;
        cnt_inc   = 1'b0;
        if (FLUSH) begin
            state_nxt = IDLE;
            k_nxt     = '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mode_nxt  = MODE;
                    k_nxt     = k + LOGN'(1);
                    state_nxt = FILL;
                end
                FILL: if (accept) begin
                    if (k == K_LAST) begin
                        k_nxt     = '0;
                        state_nxt = FULL;
                        cnt_inc   = 1'b1;
                    end else begin
                        k_nxt = k + LOGN'(1);
                    end
                end
                FULL: if (BLK_ACK) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            k       <= '0;
            mode_q  <= 1'b0;
            BLK_CNT <= 8'd0;
        end else begin
            state  <= state_nxt;
            k      <= k_nxt;
            mode_q <= mode_nxt;
            if (cnt_inc) BLK_CNT <= BLK_CNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_block_load_ctrl.sv
// tb_block_load_ctrl: randomized + directed bench with a reference model and
// a scoreboard; the driver pushes expected responses, a monitor pops them.
module tb_block_load_ctrl;

    localparam int W    = 8;
    localparam int N    = 16;
    localparam int LOGN = 4;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            PIX_VALID = 1'b0;
    logic [W-1:0]    PIX_DATA = '0;
    logic            PIX_READY;
    logic            MODE = 1'b0;
    logic            FLUSH = 1'b0;
    logic            WR;
    logic [LOGN-1:0] ADDR_W;
    logic [W-1:0]    DATA_W;
    logic            BLK_VALID;
    logic            BLK_ACK = 1'b0;
    logic [7:0]      BLK_CNT;

    block_load_ctrl #(.W(W), .N(N), .LOGN(LOGN)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PIX_VALID (PIX_VALID),
        .PIX_DATA  (PIX_DATA),
        .PIX_READY (PIX_READY),
        .MODE      (MODE),
        .FLUSH     (FLUSH),
        .WR        (WR),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BLK_VALID (BLK_VALID),
        .BLK_ACK   (BLK_ACK),
        .BLK_CNT   (BLK_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         wr;
        bit         ready;
        bit         bv;
        logic [7:0] cnt;
    } status_t;

    typedef struct {
        logic [LOGN-1:0] addr;
        logic [W-1:0]    data;
    } wr_t;

    status_t    sq[$];
    wr_t        wq[$];
    logic [W-1:0] tb_reg [N];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: block-level view (pixels so far, full flag, count).
    int         m_n    = 0;
    bit         m_full = 0;
    bit         m_mode = 0;
    logic [7:0] m_cnt  = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        status_t s;
        wr_t     w;
        if (sq.size() > 0) begin
            s = sq.pop_front();
            check("pix_ready", {31'd0, PIX_READY}, {31'd0, s.ready});
            check("wr",        {31'd0, WR},        {31'd0, s.wr});
            check("blk_valid", {31'd0, BLK_VALID}, {31'd0, s.bv});
            check("blk_cnt",   {24'd0, BLK_CNT},   {24'd0, s.cnt});
        end
        if (WR === 1'b1) begin
            if (wq.size() == 0) begin
                check("wr_unexpected", {31'd0, WR}, 32'd0);
            end else begin
                w = wq.pop_front();
                check("addr_w", {28'd0, ADDR_W}, {28'd0, w.addr});
                check("data_w", {24'd0, DATA_W}, {24'd0, w.data});
            end
            tb_reg[ADDR_W] = DATA_W;
        end
    end

    // One clock cycle: drive inputs, predict this cycle's outputs, advance model.
    task automatic cycle(input bit rst, input bit valid, input logic [W-1:0] data,
                         input bit mode, input bit flush, input bit ack, output bit acc);
        status_t s;
        wr_t     w;
        bit      md;
        RST = rst; PIX_VALID = valid; PIX_DATA = data;
        MODE = mode; FLUSH = flush; BLK_ACK = ack;
        if (rst) begin
            m_full = 0; m_n = 0; m_mode = 0; m_cnt = 8'd0;
        end
        s.ready = !rst && !flush && !m_full;
        acc     = valid && s.ready;
        s.wr    = acc;
        s.bv    = m_full;
        s.cnt   = m_cnt;
        sq.push_back(s);
        if (acc) begin
            md     = (m_n == 0) ? mode : m_mode;
            w.addr = md ? LOGN'((m_n % 4) * 4 + m_n / 4) : LOGN'(m_n);
            w.data = data;
            wq.push_back(w);
        end
        if (!rst) begin
            if (flush) begin
                m_full = 0; m_n = 0;
            end else if (m_full) begin
                if (ack) m_full = 0;
            end else if (acc) begin
                if (m_n == 0) m_mode = mode;
                m_n++;
                if (m_n == N) begin
                    m_n = 0; m_full = 1; m_cnt = m_cnt + 8'd1;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0, 0, acc);
    endtask

    // Feed pixels 0..count-1; MODE is randomised after the first pixel.
    task automatic feed(input bit mode, input bit gap, input int count);
        bit acc;
        bit md;
        int i = 0;
        int guard = 0;
        while (i < count && guard < 200) begin
            md = (i == 0) ? mode : 1'($urandom_range(0, 1));
            cycle(0, 1, W'(i), md, 0, 0, acc);
            if (acc) i++;
            if (gap) cycle(0, 0, W'($urandom), ~md, 0, 0, acc);
            guard++;
        end
        check("feed_done", i, count);
    endtask

    task automatic ack_block();
        bit acc;
        cycle(0, 0, '0, 0, 0, 1, acc);
    endtask

    initial begin
        bit         acc;
        logic [7:0] cnt_save;

        repeat (2) @(posedge CLK);
        #1;
        cycle(1, 1, 8'hAA, 0, 0, 0, acc);
        cycle(1, 0, '0, 0, 0, 0, acc);
        idle(1);

        // Row-major, back-to-back; BLK_VALID in cycle 17.
        feed(0, 0, 16);
        idle(1);
        check("cnt_after_first", {24'd0, BLK_CNT}, 32'd1);
        ack_block();

        // Column-major: register contents are the transpose.
        feed(1, 0, 16);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                check("transpose", {24'd0, tb_reg[r*4+c]}, 32'(c*4 + r));
        ack_block();

        // PIX_VALID toggling every other cycle.
        feed(0, 1, 16);
        ack_block();

        // PIX_VALID held through FULL, ACK cycle refuses, next accept at 0.
        feed(1, 0, 16);
        cycle(0, 1, 8'h55, 0, 0, 0, acc);
        cycle(0, 1, 8'h56, 0, 0, 1, acc);
        check("ack_cycle_no_accept", {31'd0, acc}, 32'd0);
        cycle(0, 1, 8'h57, 0, 0, 0, acc);
        check("accept_after_ack", {31'd0, acc}, 32'd1);

        // FLUSH after 7 accepts.
        cycle(0, 0, '0, 0, 1, 0, acc);
        cnt_save = BLK_CNT;
        feed(1, 0, 7);
        cycle(0, 1, 8'h77, 0, 1, 1, acc);
        cycle(0, 1, 8'h78, 0, 0, 0, acc);
        check("cnt_after_flush", {24'd0, BLK_CNT}, {24'd0, cnt_save});
        cycle(0, 0, '0, 0, 1, 0, acc);

        // Reset mid-FILL, then reset from FULL.
        feed(0, 0, 5);
        cycle(1, 1, 8'h11, 0, 0, 0, acc);
        idle(3);
        feed(0, 0, 16);
        cycle(1, 0, '0, 0, 0, 0, acc);
        idle(1);

        // 256 blocks: BLK_CNT wraps to 0.
        for (int b = 0; b < 256; b++) begin
            feed(1'($urandom_range(0, 1)), 0, 16);
            ack_block();
        end
        check("cnt_wrap", {24'd0, BLK_CNT}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, W'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) == 0, acc);
        end

        idle(2);
        @(negedge CLK);
        #1;
        check("status_queue_drained", sq.size(), 32'd0);
        check("write_queue_drained", wq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/block_load_ctrl.md
BLOCK_LOAD_CTRL -- requirements
Module: block_load_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, pixel width in bits.
REQ-002 SHALL have parameter N, default 16, pixels per 4x4 block.
REQ-003 SHALL have parameter LOGN, default 4, address width.
REQ-004 SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port PIX_VALID, input, 1, upstream pixel present.
REQ-007 SHALL have port PIX_DATA, input, W, upstream pixel value.
REQ-008 SHALL have port PIX_READY, output, 1, pixel accepted this cycle when PIX_VALID is also high.
REQ-009 SHALL have port MODE, input, 1, write order: 0 = row-major, 1 = column-major (transpose).
REQ-010 SHALL have port FLUSH, input, 1, synchronous abort of the current block.
REQ-011 SHALL have port WR, output, 1, write strobe to the 4x4 block register.
REQ-012 SHALL have port ADDR_W, output, LOGN, block register write address.
REQ-013 SHALL have port DATA_W, output, W, block register write data.
REQ-014 SHALL have port BLK_VALID, output, 1, block register holds a complete block.
REQ-015 SHALL have port BLK_ACK, input, 1, downstream has consumed the block.
REQ-016 SHALL have port BLK_CNT, output, 8, count of completed blocks, wraps 255 -> 0.

Function
REQ-017 SHALL implement states IDLE, FILL and FULL.
REQ-018 SHALL drive PIX_READY = 1 in IDLE and FILL, and 0 in FULL or while FLUSH = 1.
REQ-019 SHALL define accept as PIX_VALID & PIX_READY, with WR = accept, DATA_W = PIX_DATA and zero added latency (register written on the same edge).
REQ-020 SHALL hold a 4-bit pixel counter k; ADDR_W = k for order 0, and ADDR_W = {k[1:0], k[3:2]} for order 1.
REQ-021 SHALL latch MODE on the accept with k = 0 (in IDLE) and keep it for the whole block; MODE changes mid-block SHALL be ignored.
REQ-022 SHALL, in IDLE, move to FILL with k = 1 on accept.
REQ-023 SHALL, in FILL, increment k on each accept; on the accept with k = 15, k wraps to 0 and the state moves to FULL.
REQ-024 SHALL assert BLK_VALID only in FULL, i.e. in the cycle after the 16th write.
REQ-025 SHALL increment BLK_CNT on the FILL -> FULL transition.
REQ-026 SHALL, in FULL, go to IDLE on BLK_ACK; no pixel is accepted in the ACK cycle, so the earliest next accept is the following cycle.
REQ-027 SHALL ignore BLK_ACK outside FULL.
REQ-028 SHALL, when FLUSH = 1, force IDLE with k = 0 on the next edge and suppress WR; BLK_CNT SHALL be unchanged.
REQ-029 SHALL give FLUSH priority over BLK_ACK and accept; the block register contents are not cleared.
REQ-030 SHALL keep WR = 0 whenever PIX_VALID = 0; gaps SHALL stall k without loss.

Reset
REQ-031 SHALL, while RST = 1, set state IDLE, k = 0, latched mode 0, BLK_CNT 0, BLK_VALID 0 and WR 0.
REQ-032 SHALL drive PIX_READY 0 while RST = 1, and 1 from the first cycle after release.
REQ-033 SHALL, on reset mid-FILL, discard the partial block with no BLK_VALID pulse.

Structure
REQ-034 SHALL place the state encoding (IDLE, FILL, FULL) and the default W, N and LOGN in a shared package block_pkg.
REQ-035 SHALL use one sub-module, blk_addr_map (k, mode -> ADDR_W), for the address mapping; everything else is flat.
REQ-036 SHALL be instantiable directly in front of the 4x4 block register, with WR, ADDR_W and DATA_W wired one-to-one.

Verification
REQ-037 SHALL cover: MODE 0, 16 back-to-back pixels 0..15 -> ADDR_W 0..15; BLK_VALID high in cycle 17; BLK_CNT = 1.
REQ-038 SHALL cover: MODE 1, pixels 0..15 -> ADDR_W sequence 0,4,8,12,1,5,...,15; packed register output is the transpose.
REQ-039 SHALL cover: PIX_VALID toggling every other cycle -> 16 writes, no duplicate or skipped address; BLK_VALID after the 16th accept.
REQ-040 SHALL cover: PIX_VALID held high through FULL; ACK in cycle t -> PIX_READY 0 in t, first new accept in t+1 at ADDR_W 0.
REQ-041 SHALL cover: FLUSH after 7 accepts -> IDLE, next accept at ADDR_W 0, BLK_CNT unchanged; RST asserted mid-FILL -> all outputs reset asynchronously.
REQ-042 SHALL cover: 256 complete blocks -> BLK_CNT wraps to 0.
